// File: rtl/riscv_io_pkg.sv
// Shared definitions for the picorv32 stream port block: register offsets
// inside a 16-byte channel window, the bus FSM state type and a helper
// that assembles the status word.
package riscv_io_pkg;

  // Byte offsets inside one channel window (only bits [3:2] are decoded)
  localparam logic [3:0] OFF_TX   = 4'h0;
  localparam logic [3:0] OFF_RX   = 4'h4;
  localparam logic [3:0] OFF_STAT = 4'h8;
  localparam logic [3:0] OFF_RSVD = 4'hC;

  // Bus handshake states: wait for a completable request, then pulse ready
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } bus_state_t;

  // Status layout: bit0 TX full, bit1 RX empty, [15:8] TX count, [23:16] RX count
  function automatic logic [31:0] status_word(
    input logic       tx_full,
    input logic       rx_empty,
    input logic [7:0] tx_cnt,
    input logic [7:0] rx_cnt
  );
    return {8'h00, rx_cnt, tx_cnt, 6'b0, rx_empty, tx_full};
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO used for every TX and RX queue of the stream ports.
// The head entry is read combinationally so the stream side can present it
// directly on its data output. Push while full and pop while empty are
// ignored, so callers may gate loosely without corrupting the pointers.
module stream_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr_reg];

  // Storage write; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; power-of-two depth makes pointers wrap naturally
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/riscv_stream_ports.sv
// Memory-mapped stream ports for a picorv32 core. Each channel has a
// 16-byte window holding a TX data register (CPU -> stream), an RX data
// register (stream -> CPU) and a status register. Accesses that cannot
// complete yet (TX full, RX empty) simply stall: the request is held by
// the core until the FIFO state allows it, and mem_ready pulses one cycle
// after the cycle in which the push or pop was performed.
module riscv_stream_ports
  import riscv_io_pkg::*;
#(
  parameter int          NUM_CH     = 5,
  parameter int          DATA_WIDTH = 32,
  parameter int          DEPTH      = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h2000_0000
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         mem_valid,
  input  logic [31:0]                  mem_addr,
  input  logic [31:0]                  mem_wdata,
  input  logic [3:0]                   mem_wstrb,
  output logic                         mem_ready,
  output logic [31:0]                  mem_rdata,
  output logic                         hit,
  input  logic [NUM_CH-1:0]            val_in,
  input  logic [NUM_CH*DATA_WIDTH-1:0] din,
  output logic [NUM_CH-1:0]            ready_upward,
  output logic [NUM_CH-1:0]            val_out,
  output logic [NUM_CH*DATA_WIDTH-1:0] dout,
  input  logic [NUM_CH-1:0]            ready_downward
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Address decode fields
  logic [3:0] ch_idx;
  logic [1:0] reg_idx;
  logic       is_wr;
  logic       sel_tx;
  logic       sel_rx;
  logic       sel_stat;

  // Per-channel FIFO views
  logic [NUM_CH-1:0]     ch_sel;
  logic [NUM_CH-1:0]     tx_full;
  logic [NUM_CH-1:0]     tx_empty;
  logic [NUM_CH-1:0]     rx_full;
  logic [NUM_CH-1:0]     rx_empty;
  logic [NUM_CH-1:0]     tx_push;
  logic [NUM_CH-1:0]     tx_pop;
  logic [NUM_CH-1:0]     rx_push;
  logic [NUM_CH-1:0]     rx_pop;
  logic [DATA_WIDTH-1:0] tx_head  [NUM_CH];
  logic [DATA_WIDTH-1:0] rx_head  [NUM_CH];
  logic [CW-1:0]         tx_count [NUM_CH];
  logic [CW-1:0]         rx_count [NUM_CH];
  logic [31:0]           ch_status[NUM_CH];

  // Values of the channel addressed by the current request
  logic                  cur_tx_full;
  logic                  cur_rx_empty;
  logic [DATA_WIDTH-1:0] cur_rx_head;
  logic [31:0]           cur_status;

  // Bus FSM
  bus_state_t  state_reg;
  logic        ready_reg;
  logic [31:0] rdata_reg;
  logic [31:0] rdata_next;
  logic        stall;
  logic        accept;

  // Byte-lane bits are not part of the register decode
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_addr[1:0];

  // The window is 256-byte aligned, so the upper address bits identify it and
  // bits [7:4] select the channel; widen to 5 bits so NUM_CH=16 compares cleanly
  assign hit = mem_valid
            && (mem_addr[31:8] == BASE_ADDR[31:8])
            && ({1'b0, mem_addr[7:4]} < 5'(NUM_CH));

  assign ch_idx   = mem_addr[7:4];
  assign reg_idx  = mem_addr[3:2];
  assign is_wr    = |mem_wstrb;
  assign sel_tx   = (reg_idx == OFF_TX[3:2]);
  assign sel_rx   = (reg_idx == OFF_RX[3:2]);
  assign sel_stat = (reg_idx == OFF_STAT[3:2]);

  // Stream-side handshakes: present TX head downstream, accept upstream when RX has room
  assign val_out      = ~tx_empty;
  assign ready_upward = ~rx_full;
  assign tx_pop       = val_out & ready_downward;
  assign rx_push      = val_in & ready_upward;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_sel[gi]  = hit && (ch_idx == 4'(gi));
      // CPU-side push/pop only fire in the cycle the request is accepted
      assign tx_push[gi] = accept && ch_sel[gi] && is_wr && sel_tx;
      assign rx_pop[gi]  = accept && ch_sel[gi] && !is_wr && sel_rx;

      assign dout[gi*DATA_WIDTH +: DATA_WIDTH] = tx_head[gi];
      assign ch_status[gi] = status_word(tx_full[gi], rx_empty[gi],
                                         8'(tx_count[gi]), 8'(rx_count[gi]));

      stream_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (DEPTH)
      ) u_tx_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (tx_push[gi]),
        .push_data (mem_wdata[DATA_WIDTH-1:0]),
        .pop       (tx_pop[gi]),
        .head      (tx_head[gi]),
        .full      (tx_full[gi]),
        .empty     (tx_empty[gi]),
        .count     (tx_count[gi])
      );

      stream_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (DEPTH)
      ) u_rx_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (rx_push[gi]),
        .push_data (din[gi*DATA_WIDTH +: DATA_WIDTH]),
        .pop       (rx_pop[gi]),
        .head      (rx_head[gi]),
        .full      (rx_full[gi]),
        .empty     (rx_empty[gi]),
        .count     (rx_count[gi])
      );
    end
  endgenerate

  // Select the addressed channel's FIFO state; ch_sel is one-hot or all zero
  always_comb begin
    cur_tx_full  = 1'b0;
    cur_rx_empty = 1'b0;
    cur_rx_head  = '0;
    cur_status   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_sel[c]) begin
        cur_tx_full  = tx_full[c];
        cur_rx_empty = rx_empty[c];
        cur_rx_head  = rx_head[c];
        cur_status   = ch_status[c];
      end
    end
  end

  // Stall decision uses current occupancy only, so a same-cycle stream pop or
  // push never lets the CPU slip into a full TX or an empty RX
  assign stall  = (is_wr && sel_tx && cur_tx_full)
               || (!is_wr && sel_rx && cur_rx_empty);
  assign accept = hit && (state_reg == ST_IDLE) && !stall;

  // Read data: RX head zero-extended, status word, everything else reads zero
  always_comb begin
    rdata_next = '0;
    if (!is_wr) begin
      if (sel_rx) begin
        rdata_next[DATA_WIDTH-1:0] = cur_rx_head;
      end else if (sel_stat) begin
        rdata_next = cur_status;
      end
    end
  end

  // Bus FSM: capture the response on accept, pulse mem_ready for one cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= ST_IDLE;
      ready_reg <= 1'b0;
      rdata_reg <= '0;
    end else if (state_reg == ST_RESP) begin
      state_reg <= ST_IDLE;
      ready_reg <= 1'b0;
    end else if (accept) begin
      state_reg <= ST_RESP;
      ready_reg <= 1'b1;
      rdata_reg <= rdata_next;
    end
  end

  assign mem_ready = ready_reg;
  assign mem_rdata = rdata_reg;

endmodule

// File: tb/tb_riscv_stream_ports.sv
// Self-checking bench for riscv_stream_ports: a vector table of immediate
// register accesses, hand-written stall/reset/decode sequences, and
// scoreboards for the TX (to stream) and RX (from stream) data paths.
module tb_riscv_stream_ports;

  localparam int          NCH  = 5;
  localparam int          DW   = 32;
  localparam int          DEP  = 4;
  localparam logic [31:0] BASE = 32'h2000_0000;

  logic              clk;
  logic              resetn;
  logic              mem_valid;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_ready;
  logic [31:0]       mem_rdata;
  logic              hit;
  logic [NCH-1:0]    val_in;
  logic [NCH*DW-1:0] din;
  logic [NCH-1:0]    ready_upward;
  logic [NCH-1:0]    val_out;
  logic [NCH*DW-1:0] dout;
  logic [NCH-1:0]    ready_downward;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          ch;
    logic [31:0] data;
  } sb_t;

  sb_t tx_q[$];
  sb_t rx_q[$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        chk_rd;
    logic [31:0] exp_rd;
    int          tx_ch;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  riscv_stream_ports #(
    .NUM_CH     (NCH),
    .DATA_WIDTH (DW),
    .DEPTH      (DEP),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .mem_valid      (mem_valid),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wstrb      (mem_wstrb),
    .mem_ready      (mem_ready),
    .mem_rdata      (mem_rdata),
    .hit            (hit),
    .val_in         (val_in),
    .din            (din),
    .ready_upward   (ready_upward),
    .val_out        (val_out),
    .dout           (dout),
    .ready_downward (ready_downward)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One bus request held until mem_ready or the cycle budget expires
  task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int budget,
                          output bit ok, output logic [31:0] rd, output int lat);
    @(posedge clk); #1;
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    ok  = 1'b0;
    rd  = '0;
    lat = 0;
    while (!ok && lat < budget) begin
      @(posedge clk); #1;
      lat++;
      if (mem_ready) begin
        ok = 1'b1;
        rd = mem_rdata;
      end
    end
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
  endtask

  // Write to a TX register expecting single-cycle completion; record for the TX scoreboard
  task automatic tx_write(input int c, input logic [31:0] data, input string name);
    bit ok; logic [31:0] rd; int lat;
    bus_xfer(BASE + 32'(16*c), data, 4'hF, 10, ok, rd, lat);
    check(name, 32'(lat), 32'd1);
    if (ok) tx_q.push_back('{ch: c, data: data});
  endtask

  // Drive one upstream beat on channel c
  task automatic stream_push(input int c, input logic [31:0] data);
    @(posedge clk); #1;
    val_in[c] = 1'b1;
    din[c*DW +: DW] = data;
    @(posedge clk); #1;
    val_in[c] = 1'b0;
  endtask

  // Compare RX read data against the oldest recorded upstream beat of channel c
  task automatic rx_check(input int c, input logic [31:0] act, input string name);
    int idx;
    idx = -1;
    for (int k = 0; k < rx_q.size(); k++) if (idx < 0 && rx_q[k].ch == c) idx = k;
    if (idx < 0) begin
      checks++;
      failures++;
      $display("FAIL %s actual=%h required=no_rx_data", name, act);
    end else begin
      check(name, act, rx_q[idx].data);
      rx_q.delete(idx);
    end
  endtask

  task automatic rx_read(input int c, input string name);
    bit ok; logic [31:0] rd; int lat;
    bus_xfer(BASE + 32'(16*c) + 32'h4, 32'h0, 4'h0, 10, ok, rd, lat);
    check({name, "_lat"}, 32'(lat), 32'd1);
    rx_check(c, rd, name);
  endtask

  task automatic status_read(input int c, input logic [31:0] exp, input string name);
    bit ok; logic [31:0] rd; int lat;
    bus_xfer(BASE + 32'(16*c) + 32'h8, 32'h0, 4'h0, 10, ok, rd, lat);
    check({name, "_lat"}, 32'(lat), 32'd1);
    check(name, rd, exp);
  endtask

  function automatic int pending_tx(input int c);
    int n;
    n = 0;
    foreach (tx_q[k]) if (tx_q[k].ch == c) n++;
    return n;
  endfunction

  // Non-hit address: hit must stay low and no completion may appear
  task automatic no_hit(input logic [31:0] addr, input string name);
    bit seen;
    @(posedge clk); #1;
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wstrb = 4'h0;
    #1;
    check({name, "_hit"}, 32'(hit), 32'd0);
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (mem_ready) seen = 1'b1;
    end
    check({name, "_ready"}, 32'(seen), 32'd0);
    mem_valid = 1'b0;
  endtask

  // Stream monitor: TX beats are checked in order per channel, RX beats recorded
  always @(negedge clk) begin : monitor
    int idx;
    if (resetn) begin
      for (int c = 0; c < NCH; c++) begin
        if (val_out[c] && ready_downward[c]) begin
          idx = -1;
          for (int k = 0; k < tx_q.size(); k++) if (idx < 0 && tx_q[k].ch == c) idx = k;
          if (idx < 0) begin
            checks++;
            failures++;
            $display("FAIL tx_unexpected_ch%0d actual=%h required=no_beat", c, dout[c*DW +: DW]);
          end else begin
            check($sformatf("tx_order_ch%0d", c), dout[c*DW +: DW], tx_q[idx].data);
            tx_q.delete(idx);
          end
        end
        if (val_in[c] && ready_upward[c]) rx_q.push_back('{ch: c, data: din[c*DW +: DW]});
      end
    end
  end

  initial begin : stim
    bit          ok;
    bit          seen;
    logic [31:0] rd;
    int          lat;

    // Immediate accesses on channel 3 with its downstream held off
    vecs[0]  = '{addr: BASE + 32'h38, wdata: 32'h0,         wstrb: 4'h0, chk_rd: 1'b1, exp_rd: 32'h0000_0002, tx_ch: -1};
    vecs[1]  = '{addr: BASE + 32'h30, wdata: 32'h0000_0011, wstrb: 4'hF, chk_rd: 1'b0, exp_rd: 32'h0,         tx_ch: 3};
    vecs[2]  = '{addr: BASE + 32'h38, wdata: 32'h0,         wstrb: 4'h0, chk_rd: 1'b1, exp_rd: 32'h0000_0102, tx_ch: -1};
    vecs[3]  = '{addr: BASE + 32'h30, wdata: 32'hFFFF_FF22, wstrb: 4'h1, chk_rd: 1'b0, exp_rd: 32'h0,         tx_ch: 3};
    vecs[4]  = '{addr: BASE + 32'h38, wdata: 32'h0,         wstrb: 4'h0, chk_rd: 1'b1, exp_rd: 32'h0000_0202, tx_ch: -1};
    vecs[5]  = '{addr: BASE + 32'h34, wdata: 32'h0000_DEAD, wstrb: 4'hF, chk_rd: 1'b1, exp_rd: 32'h0,         tx_ch: -1};
    vecs[6]  = '{addr: BASE + 32'h38, wdata: 32'h0000_0001, wstrb: 4'hF, chk_rd: 1'b1, exp_rd: 32'h0,         tx_ch: -1};
    vecs[7]  = '{addr: BASE + 32'h3C, wdata: 32'h1234_5678, wstrb: 4'hF, chk_rd: 1'b1, exp_rd: 32'h0,         tx_ch: -1};
    vecs[8]  = '{addr: BASE + 32'h30, wdata: 32'h0,         wstrb: 4'h0, chk_rd: 1'b1, exp_rd: 32'h0,         tx_ch: -1};
    vecs[9]  = '{addr: BASE + 32'h3C, wdata: 32'h0,         wstrb: 4'h0, chk_rd: 1'b1, exp_rd: 32'h0,         tx_ch: -1};
    vecs[10] = '{addr: BASE + 32'h3B, wdata: 32'h0,         wstrb: 4'h0, chk_rd: 1'b1, exp_rd: 32'h0000_0202, tx_ch: -1};
    vecs[11] = '{addr: BASE + 32'h38, wdata: 32'h0,         wstrb: 4'h0, chk_rd: 1'b1, exp_rd: 32'h0000_0202, tx_ch: -1};

    resetn         = 1'b0;
    mem_valid      = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    mem_wstrb      = 4'h0;
    val_in         = '0;
    din            = '0;
    ready_downward = '0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    #1;
    check("rst_ready",    32'(mem_ready),    32'd0);
    check("rst_rdata",    mem_rdata,         32'd0);
    check("rst_val_out",  32'(val_out),      32'd0);
    check("rst_ready_up", 32'(ready_upward), 32'h1F);

    // Single TX write with downstream ready: data appears with the completion
    ready_downward[0] = 1'b1;
    bus_xfer(BASE, 32'h0000_00A5, 4'hF, 10, ok, rd, lat);
    check("tx0_lat", 32'(lat), 32'd1);
    if (ok) tx_q.push_back('{ch: 0, data: 32'h0000_00A5});
    check("tx0_val_out", 32'(val_out[0]), 32'd1);
    check("tx0_dout",    dout[31:0],      32'h0000_00A5);

    // Vector table
    for (int i = 0; i < NV; i++) begin
      bus_xfer(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, 10, ok, rd, lat);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'd1);
      if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      if (ok && vecs[i].tx_ch >= 0) tx_q.push_back('{ch: vecs[i].tx_ch, data: vecs[i].wdata});
    end
    ready_downward[3] = 1'b1;
    repeat (6) @(posedge clk);
    check("vec_tx3_drained", 32'(pending_tx(3)), 32'd0);

    // TX full on channel 2: fifth write stalls until downstream drains
    for (int i = 1; i <= 4; i++) tx_write(2, 32'h0222_0000 + 32'(i), $sformatf("tx2_w%0d_lat", i));
    status_read(2, 32'h0000_0403, "tx2_full_status");
    seen = 1'b0;
    fork
      bus_xfer(BASE + 32'h20, 32'h0222_0005, 4'hF, 40, ok, rd, lat);
      begin
        repeat (8) begin
          @(posedge clk); #2;
          if (mem_ready) seen = 1'b1;
        end
        ready_downward[2] = 1'b1;
      end
    join
    check("tx2_stall_no_ready", 32'(seen), 32'd0);
    check("tx2_w5_done",        32'(ok),   32'd1);
    check("tx2_w5_late",        32'(lat > 8), 32'd1);
    if (ok) tx_q.push_back('{ch: 2, data: 32'h0222_0005});
    repeat (10) @(posedge clk);
    check("tx2_drained", 32'(pending_tx(2)), 32'd0);

    // RX read from empty channel 1 stalls until a beat arrives
    fork
      bus_xfer(BASE + 32'h14, 32'h0, 4'h0, 30, ok, rd, lat);
      begin
        repeat (4) @(posedge clk);
        stream_push(1, 32'h0000_1234);
      end
    join
    check("rx1_done",  32'(ok), 32'd1);
    check("rx1_late",  32'(lat >= 3), 32'd1);
    check("rx1_rdata", rd, 32'h0000_1234);
    rx_check(1, rd, "rx1_sb");

    // RX counting, simultaneous push/pop, full, and pointer wrap on channel 4
    for (int i = 1; i <= 3; i++) stream_push(4, 32'h0444_0000 + 32'(i));
    status_read(4, 32'h0003_0000, "rx4_status3");
    fork
      bus_xfer(BASE + 32'h44, 32'h0, 4'h0, 10, ok, rd, lat);
      stream_push(4, 32'h0444_0004);
    join
    check("rx4_pp_lat", 32'(lat), 32'd1);
    rx_check(4, rd, "rx4_pp_data");
    status_read(4, 32'h0003_0000, "rx4_status_pp");
    stream_push(4, 32'h0444_0005);
    check("rx4_full_ready", 32'(ready_upward[4]), 32'd0);
    status_read(4, 32'h0004_0000, "rx4_status_full");
    stream_push(4, 32'h0444_0006);
    for (int i = 0; i < 4; i++) rx_read(4, $sformatf("rx4_drain%0d", i));
    status_read(4, 32'h0000_0002, "rx4_status_empty");

    // Address decode edges
    @(posedge clk); #1;
    mem_valid = 1'b0;
    mem_addr  = BASE;
    #1 check("idle_hit", 32'(hit), 32'd0);
    mem_valid = 1'b1;
    mem_addr  = BASE + 32'h4F;
    #1 check("last_word_hit", 32'(hit), 32'd1);
    mem_valid = 1'b0;
    no_hit(BASE + 32'(16*NCH), "past_end");
    no_hit(BASE + 32'h100,     "next_window");
    no_hit(BASE - 32'h4,       "below_base");

    // Reset during a stalled TX write on channel 0
    ready_downward[0] = 1'b0;
    for (int i = 1; i <= 4; i++) tx_write(0, 32'h0000_0B00 + 32'(i), $sformatf("tx0_fill%0d_lat", i));
    fork
      bus_xfer(BASE, 32'h0000_0BFF, 4'hF, 6, ok, rd, lat);
      begin
        repeat (3) @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        check("arst_ready",   32'(mem_ready), 32'd0);
        check("arst_val_out", 32'(val_out),   32'd0);
      end
    join
    check("arst_no_complete", 32'(ok), 32'd0);
    @(posedge clk); #1 resetn = 1'b1;
    tx_q.delete();
    rx_q.delete();
    #1;
    check("post_rst_ready",    32'(mem_ready),    32'd0);
    check("post_rst_rdata",    mem_rdata,         32'd0);
    check("post_rst_val_out",  32'(val_out),      32'd0);
    check("post_rst_ready_up", 32'(ready_upward), 32'h1F);
    status_read(0, 32'h0000_0002, "post_rst_status");
    ready_downward[0] = 1'b1;
    tx_write(0, 32'h0000_0077, "post_rst_tx_lat");
    repeat (5) @(posedge clk);
    check("final_tx_empty", 32'(tx_q.size()), 32'd0);
    check("final_rx_empty", 32'(rx_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
